o232c_fifo: RTL and testbench

RS-232C transmit path for the board-level UART: 8N1 serializer with a small byte FIFO in front, so the core can post several bytes without waiting for the line. Sits inside `top` between the CPU's output port and the `RS_TX` pin. It is the transmit counterpart of `i232c` and must be decodable by `i232c` running at the same bit period.

---
 rtl/o232c_fifo.sv | 123 ++++++++++++
 tb/tb_o232c_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/o232c_fifo.sv
// rtl/o232c_fifo.sv - 8N1 RS-232C transmitter with a circular byte FIFO in front
module o232c_fifo #(
  parameter int WAIT_COUNT = 620,
  parameter int DEPTH_LOG  = 4
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic [7:0]         data,
  input  logic               go,
  output logic               full,
  output logic               busy,
  output logic [DEPTH_LOG:0] count,
  output logic               tx
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int TW    = $clog2(WAIT_COUNT);

  localparam logic [TW-1:0]        T_LAST   = TW'(WAIT_COUNT - 1);
  localparam logic [TW-1:0]        T_ONE    = TW'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);
  localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG + 1)'(1);
  localparam logic [DEPTH_LOG:0]   CNT_FULL = (DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               state;
  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] wptr;
  logic [DEPTH_LOG-1:0] rptr;
  logic [7:0]           shift;
  logic [2:0]           bit_idx;
  logic [TW-1:0]        timer;
  logic                 timer_done;
  logic                 push;
  logic                 pop;

  // full comes from the registered count, so a same-cycle pop never makes room for a push
  assign full       = (count == CNT_FULL);
  assign busy       = (state != S_IDLE) || (count != '0);
  assign timer_done = (timer == T_LAST);
  assign push       = go && !full;
  assign pop        = (count != '0) && ((state == S_IDLE) || ((state == S_STOP) && timer_done));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // tx is only ever updated on bit boundaries, straight from a flop
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift <= mem[rptr];
            timer <= '0;
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (timer_done) begin
            timer   <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            timer <= timer + T_ONE;
          end
        end
        S_DATA: begin
          if (timer_done) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            timer <= timer + T_ONE;
          end
        end
        S_STOP: begin
          if (timer_done) begin
            timer <= '0;
            // chain straight into the next start bit when more bytes wait
            if (pop) begin
              shift <= mem[rptr];
              tx    <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + T_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_o232c_fifo.sv
// tb/tb_o232c_fifo.sv - table-driven bench for o232c_fifo with a line decoder
module tb_o232c_fifo;
  localparam int W  = 4;
  localparam int DL = 2;
  localparam int WS = 620;

  typedef struct {
    logic [7:0] d;
    logic [9:0] line;
  } vec_t;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic go = 1'b0;
  logic go_s = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] data_s = 8'h00;
  logic full, busy, tx;
  logic full_s, busy_s, tx_s;
  logic [DL:0] count;
  logic [4:0] count_s;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int rx_t[$];
  int dec_n, dec_t, dec_b;
  int dec_ferr = 0;
  bit dec_on = 1'b0;
  logic [7:0] dec_sh;

  o232c_fifo #(.WAIT_COUNT(W), .DEPTH_LOG(DL)) dut (
    .clk(clk), .xrst(xrst), .data(data), .go(go),
    .full(full), .busy(busy), .count(count), .tx(tx)
  );

  o232c_fifo #(.WAIT_COUNT(WS), .DEPTH_LOG(4)) dut_slow (
    .clk(clk), .xrst(xrst), .data(data_s), .go(go_s),
    .full(full_s), .busy(busy_s), .count(count_s), .tx(tx_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: start-edge detect, mid-bit sampling, same bit period as the fast DUT
  initial begin
    forever begin
      @(negedge clk);
      if (!xrst) begin
        dec_on = 1'b0;
      end else if (!dec_on) begin
        if (tx === 1'b0) begin
          dec_on = 1'b1;
          dec_n  = 0;
          dec_t  = cyc;
          dec_sh = 8'h00;
        end
      end else begin
        dec_n++;
        if (dec_n == W / 2 && tx !== 1'b0) begin
          dec_on = 1'b0;
        end else if (dec_n > W / 2 && ((dec_n - W / 2) % W) == 0) begin
          dec_b = (dec_n - W / 2) / W;
          if (dec_b <= 8) begin
            dec_sh = {tx, dec_sh[7:1]};
          end else begin
            if (tx !== 1'b1) dec_ferr++;
            rx_q.push_back(dec_sh);
            rx_t.push_back(dec_t);
            dec_on = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int limit);
    int i;
    i = 0;
    while (busy && i < limit) begin
      @(negedge clk);
      i++;
    end
    check("idle_timeout", 32'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [9:0] line);
    logic [3:0] obs;
    int base;
    base = rx_q.size();
    go = 1'b1;
    data = d;
    @(negedge clk);
    go = 1'b0;
    check("enq_count", 32'(count), 1);
    check("enq_tx", 32'(tx), 1);
    for (int k = 0; k < 10 * W; k++) begin
      @(negedge clk);
      obs[k % 4] = tx;
      if (k == 0) check("pop_count", 32'(count), 0);
      if (k % 4 == 3) check("line_bit", 32'(obs), 32'({4{line[k / 4]}}));
    end
    check("busy_last_stop", 32'(busy), 1);
    @(negedge clk);
    check("busy_fall", 32'(busy), 0);
    check("rx_len", rx_q.size(), base + 1);
    if (rx_q.size() > base) check("rx_byte", 32'(rx_q[base]), 32'(d));
  endtask

  initial begin
    vec_t vecs[5];
    logic [7:0] burst_d[6];
    logic [2:0] burst_cnt[6];
    logic       burst_full[6];
    logic [7:0] pp_d[4];
    logic [9:0] slow_line;
    int base, hi, m;

    vecs[0] = '{d: 8'h55, line: 10'h2AA};
    vecs[1] = '{d: 8'h00, line: 10'h200};
    vecs[2] = '{d: 8'hFF, line: 10'h3FE};
    vecs[3] = '{d: 8'h81, line: 10'h302};
    vecs[4] = '{d: 8'h3C, line: 10'h278};
    burst_d    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF};
    burst_cnt  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    burst_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pp_d       = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    slow_line  = 10'h386;

    // reset and idle line
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_slow_tx", 32'(tx_s), 1);
    check("rst_slow_busy", 32'(busy_s), 0);
    xrst = 1'b1;
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    check("idle_tx_high", hi, 100);

    // single frames from the vector table
    for (int v = 0; v < 4; v++) send_frame(vecs[v].d, vecs[v].line);

    // burst: 5 accepted, 6th dropped while full
    base = rx_q.size();
    for (int i = 0; i < 6; i++) begin
      go = 1'b1;
      data = burst_d[i];
      @(negedge clk);
      check("burst_count", 32'(count), 32'(burst_cnt[i]));
      check("burst_full", 32'(full), 32'(burst_full[i]));
    end
    go = 1'b0;
    wait_idle(400);
    check("burst_rx_len", rx_q.size(), base + 5);
    if (rx_q.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) check("burst_byte", 32'(rx_q[base + i]), 32'(burst_d[i]));
      for (int i = 1; i < 5; i++) check("burst_gap", rx_t[base + i] - rx_t[base + i - 1], 10 * W);
    end

    // push on the same edge as a STOP->START pop
    base = rx_q.size();
    for (int i = 0; i < 3; i++) begin
      go = 1'b1;
      data = pp_d[i];
      @(negedge clk);
    end
    go = 1'b0;
    check("pp_count_queued", 32'(count), 2);
    repeat (38) @(negedge clk);
    check("pp_count_pre", 32'(count), 2);
    go = 1'b1;
    data = pp_d[3];
    @(negedge clk);
    go = 1'b0;
    check("pp_count_post", 32'(count), 2);
    check("pp_next_start", 32'(tx), 0);
    wait_idle(400);
    check("pp_rx_len", rx_q.size(), base + 4);
    if (rx_q.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) check("pp_byte", 32'(rx_q[base + i]), 32'(pp_d[i]));
      for (int i = 1; i < 4; i++) check("pp_gap", rx_t[base + i] - rx_t[base + i - 1], 10 * W);
    end

    // asynchronous reset during data bit 3 of 0xA5 with two bytes queued
    go = 1'b1; data = 8'hA5; @(negedge clk);
    data = 8'h11; @(negedge clk);
    data = 8'h22; @(negedge clk);
    go = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_bit3_level", 32'(tx), 0);
    #2 xrst = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx), 1);
    check("async_rst_count", 32'(count), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_full", 32'(full), 0);
    repeat (2) @(negedge clk);
    xrst = 1'b1;
    base = rx_q.size();
    hi = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    check("post_rst_idle", hi, 60);
    check("post_rst_no_rx", rx_q.size(), base);
    send_frame(vecs[4].d, vecs[4].line);

    // pointer wrap-around with spaced single writes
    base = rx_q.size();
    for (int i = 0; i < 20; i++) begin
      go = 1'b1;
      data = 8'(i);
      @(negedge clk);
      go = 1'b0;
      repeat (49) @(negedge clk);
    end
    wait_idle(200);
    check("wrap_rx_len", rx_q.size(), base + 20);
    if (rx_q.size() >= base + 20) begin
      for (int i = 0; i < 20; i++) check("wrap_byte", 32'(rx_q[base + i]), i);
    end

    // default bit period on the second instance
    go_s = 1'b1;
    data_s = 8'hC3;
    @(negedge clk);
    go_s = 1'b0;
    check("slow_enq_count", 32'(count_s), 1);
    for (int b = 0; b < 10; b++) begin
      m = 0;
      for (int k = 0; k < WS; k++) begin
        @(negedge clk);
        if (tx_s === slow_line[b]) m++;
      end
      check("slow_bit", m, WS);
    end
    check("slow_busy_last", 32'(busy_s), 1);
    @(negedge clk);
    check("slow_busy_fall", 32'(busy_s), 0);

    check("framing_errors", dec_ferr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
